// File: rtl/term_pkg.sv
// Shared constants and FSM encoding for the text terminal write path.
package term_pkg;

    localparam int unsigned COLS_DEF       = 32;
    localparam int unsigned ROWS_DEF       = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam logic [7:0] CH_CR        = 8'h0D;
    localparam logic [7:0] CH_LF        = 8'h0A;
    localparam logic [7:0] CH_BS        = 8'h08;
    localparam logic [7:0] CH_FF        = 8'h0C;
    localparam logic [7:0] CH_SPACE     = 8'h20;
    localparam logic [7:0] CH_PRINT_MIN = 8'h20;
    localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO; a push while full is rejected even if a pop occurs.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_d = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNTW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array; contents only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/text_write_ctrl.sv
// Interprets received bytes as terminal input and issues character RAM writes.
module text_write_ctrl
    import term_pkg::*;
#(
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned ROWS       = ROWS_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [7:0]  BLANK      = CH_SPACE,
    localparam int unsigned CW        = $clog2(COLS),
    localparam int unsigned RW        = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [7:0]    wr_data,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic          busy,
    output logic          overflow
);

    localparam int unsigned SW = RW + CW;

    state_e        state_q,    state_d;
    logic [7:0]    cmd_q,      cmd_d;
    logic [RW-1:0] crow_q,     crow_d;
    logic [CW-1:0] ccol_q,     ccol_d;
    logic [SW-1:0] sweep_q,    sweep_d;
    logic          wr_en_q,    wr_en_d;
    logic [RW-1:0] wr_row_q,   wr_row_d;
    logic [CW-1:0] wr_col_q,   wr_col_d;
    logic [7:0]    wr_data_q,  wr_data_d;
    logic [RW-1:0] cur_row_q,  cur_row_d;
    logic [CW-1:0] cur_col_q,  cur_col_d;
    logic          busy_q,     busy_d;
    logic          overflow_q, overflow_d;

    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state, cursor arithmetic and write command generation.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        crow_d     = crow_q;
        ccol_d     = ccol_q;
        sweep_d    = sweep_q;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_data_d  = wr_data_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (rx_valid & fifo_full);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (cmd_q >= CH_PRINT_MIN && cmd_q <= CH_PRINT_MAX) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = crow_q;
                    wr_col_d  = ccol_q;
                    wr_data_d = cmd_q;
                    if (ccol_q == CW'(COLS - 1)) begin
                        ccol_d = '0;
                        crow_d = crow_q + RW'(1);
                    end else begin
                        ccol_d = ccol_q + CW'(1);
                    end
                end else if (cmd_q == CH_CR || cmd_q == CH_LF) begin
                    ccol_d = '0;
                    crow_d = crow_q + RW'(1);
                end else if (cmd_q == CH_BS) begin
                    // Retreat first, then blank the cell now under the cursor.
                    if (ccol_q != '0) begin
                        ccol_d = ccol_q - CW'(1);
                    end else if (crow_q != '0) begin
                        ccol_d = CW'(COLS - 1);
                        crow_d = crow_q - RW'(1);
                    end
                    wr_en_d   = 1'b1;
                    wr_row_d  = crow_d;
                    wr_col_d  = ccol_d;
                    wr_data_d = BLANK;
                end else if (cmd_q == CH_FF) begin
                    sweep_d = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_row_d  = sweep_q[SW-1:CW];
                wr_col_d  = sweep_q[CW-1:0];
                wr_data_d = BLANK;
                sweep_d   = sweep_q + SW'(1);
                if (sweep_q == {SW{1'b1}}) begin
                    crow_d  = '0;
                    ccol_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy covers the final sweep write; exported cursor lags one cycle.
        busy_d    = (state_d == ST_CLEAR) || (state_q == ST_CLEAR);
        cur_row_d = crow_q;
        cur_col_d = ccol_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            crow_q     <= '0;
            ccol_q     <= '0;
            sweep_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            crow_q     <= crow_d;
            ccol_q     <= ccol_d;
            sweep_q    <= sweep_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_data_q  <= wr_data_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_row   = wr_row_q;
    assign wr_col   = wr_col_q;
    assign wr_data  = wr_data_q;
    assign cur_row  = cur_row_q;
    assign cur_col  = cur_col_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl with hand-computed expectations.
module tb_text_write_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // {busy, row, col, data} of every write seen
    logic [15:0] wlog [$];

    always #5 clk = ~clk;

    text_write_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy),
        .overflow (overflow)
    );

    // Write logger sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wr_en === 1'b1)
            wlog.push_back({busy, wr_row, wr_col, wr_data});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        idle(2);
        reset_n = 1'b1;
        wlog.delete();
    endtask

    task automatic test_reset;
        logic [24:0] outs;
        idle(2);
        outs = {wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy, overflow};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_held: outputs got %h expected 0", outs);
        end
        reset_n = 1'b1;
        idle(2);
        outs = {wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy, overflow};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_release: outputs got %h expected 0", outs);
        end
    endtask

    task automatic test_latency;
        do_reset();
        send(8'h41);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL lat_n0: wr_en got %b expected 0", wr_en);
        end
        idle(1);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL lat_n1: wr_en got %b expected 0", wr_en);
        end
        idle(1);
        checks++;
        if ({wr_en, wr_row, wr_col, wr_data} !== {1'b1, 2'd0, 5'd0, 8'h41}) begin
            errors++;
            $display("FAIL lat_n2_write: got %h expected %h",
                     {wr_en, wr_row, wr_col, wr_data}, {1'b1, 2'd0, 5'd0, 8'h41});
        end
        checks++;
        if ({cur_row, cur_col} !== 7'd0) begin
            errors++; $display("FAIL lat_n2_cursor: got %h expected 0", {cur_row, cur_col});
        end
        idle(1);
        checks++;
        if ({cur_row, cur_col} !== {2'd0, 5'd1}) begin
            errors++; $display("FAIL lat_n3_cursor: got %h expected %h", {cur_row, cur_col}, {2'd0, 5'd1});
        end
        checks++;
        if ({wr_en, wr_data} !== {1'b0, 8'h41}) begin
            errors++; $display("FAIL lat_hold: got %h expected %h", {wr_en, wr_data}, {1'b0, 8'h41});
        end
    endtask

    task automatic test_row_wrap;
        do_reset();
        repeat (32) send(8'h42);
        idle(5);
        checks++;
        if (wlog.size() != 32) begin
            errors++; $display("FAIL row_count: got %0d expected 32", wlog.size());
        end else begin
            checks++;
            if (wlog[31] !== {1'b0, 2'd0, 5'd31, 8'h42}) begin
                errors++; $display("FAIL row_last: got %h expected %h", wlog[31], {1'b0, 2'd0, 5'd31, 8'h42});
            end
        end
        checks++;
        if ({cur_row, cur_col} !== {2'd1, 5'd0}) begin
            errors++; $display("FAIL row_cursor: got %h expected %h", {cur_row, cur_col}, {2'd1, 5'd0});
        end
        repeat (96) send(8'h42);
        idle(5);
        checks++;
        if (wlog.size() != 128) begin
            errors++; $display("FAIL wrap_count: got %0d expected 128", wlog.size());
        end else begin
            checks++;
            if (wlog[32] !== {1'b0, 2'd1, 5'd0, 8'h42} || wlog[127] !== {1'b0, 2'd3, 5'd31, 8'h42}) begin
                errors++; $display("FAIL wrap_pos: got %h/%h expected %h/%h", wlog[32], wlog[127],
                                   {1'b0, 2'd1, 5'd0, 8'h42}, {1'b0, 2'd3, 5'd31, 8'h42});
            end
        end
        checks++;
        if ({cur_row, cur_col} !== 7'd0) begin
            errors++; $display("FAIL wrap_cursor: got %h expected 0", {cur_row, cur_col});
        end
    endtask

    task automatic test_cr_lf;
        do_reset();
        send(8'h0D);
        send(8'h0D);
        repeat (5) send(8'h78);
        idle(5);
        checks++;
        if ({cur_row, cur_col} !== {2'd2, 5'd5} || wlog.size() != 5) begin
            errors++; $display("FAIL crlf_setup: cursor %h writes %0d expected %h writes 5",
                               {cur_row, cur_col}, wlog.size(), {2'd2, 5'd5});
        end
        send(8'h0D);
        idle(5);
        checks++;
        if ({cur_row, cur_col} !== {2'd3, 5'd0} || wlog.size() != 5) begin
            errors++; $display("FAIL cr: cursor %h writes %0d expected %h writes 5",
                               {cur_row, cur_col}, wlog.size(), {2'd3, 5'd0});
        end
        send(8'h0A);
        idle(5);
        checks++;
        if ({cur_row, cur_col} !== 7'd0 || wlog.size() != 5) begin
            errors++; $display("FAIL lf_wrap: cursor %h writes %0d expected 0 writes 5",
                               {cur_row, cur_col}, wlog.size());
        end
        send(8'h01);
        send(8'h7F);
        send(8'h1F);
        idle(5);
        checks++;
        if ({cur_row, cur_col} !== 7'd0 || wlog.size() != 5) begin
            errors++; $display("FAIL ignored: cursor %h writes %0d expected 0 writes 5",
                               {cur_row, cur_col}, wlog.size());
        end
        send(8'h7E);
        idle(5);
        checks++;
        if (wlog.size() != 6) begin
            errors++; $display("FAIL tilde_count: got %0d expected 6", wlog.size());
        end else begin
            checks++;
            if (wlog[5] !== {1'b0, 2'd0, 5'd0, 8'h7E}) begin
                errors++; $display("FAIL tilde_write: got %h expected %h", wlog[5], {1'b0, 2'd0, 5'd0, 8'h7E});
            end
        end
        checks++;
        if ({cur_row, cur_col} !== {2'd0, 5'd1}) begin
            errors++; $display("FAIL tilde_cursor: got %h expected %h", {cur_row, cur_col}, {2'd0, 5'd1});
        end
    endtask

    task automatic test_backspace;
        do_reset();
        send(8'h0D);
        send(8'h08);
        idle(5);
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {1'b0, 2'd0, 5'd31, 8'h20}) begin
            errors++; $display("FAIL bs_rowback: writes %0d first %h expected 1 %h",
                               wlog.size(), (wlog.size() > 0) ? wlog[0] : 16'h0, {1'b0, 2'd0, 5'd31, 8'h20});
        end
        checks++;
        if ({cur_row, cur_col} !== {2'd0, 5'd31}) begin
            errors++; $display("FAIL bs_rowback_cursor: got %h expected %h", {cur_row, cur_col}, {2'd0, 5'd31});
        end
        send(8'h08);
        idle(5);
        checks++;
        if (wlog.size() != 2 || wlog[1] !== {1'b0, 2'd0, 5'd30, 8'h20} || {cur_row, cur_col} !== {2'd0, 5'd30}) begin
            errors++; $display("FAIL bs_mid: writes %0d cursor %h expected 2 writes cursor %h",
                               wlog.size(), {cur_row, cur_col}, {2'd0, 5'd30});
        end
        do_reset();
        send(8'h08);
        idle(5);
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {1'b0, 2'd0, 5'd0, 8'h20}) begin
            errors++; $display("FAIL bs_origin: writes %0d first %h expected 1 %h",
                               wlog.size(), (wlog.size() > 0) ? wlog[0] : 16'h0, {1'b0, 2'd0, 5'd0, 8'h20});
        end
        checks++;
        if ({cur_row, cur_col} !== 7'd0) begin
            errors++; $display("FAIL bs_origin_cursor: got %h expected 0", {cur_row, cur_col});
        end
    endtask

    task automatic test_clear_overflow;
        int         k;
        logic [6:0] idx;
        logic [15:0] exp;
        do_reset();
        send(8'h0C);
        repeat (6) send(8'h43);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL clr_busy: got %b expected 1", busy);
        end
        k = 0;
        while (busy === 1'b1 && k < 400) begin
            idle(1);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clr_timeout: busy got %b expected 0 within 400 cycles", busy);
        end
        idle(10);
        checks++;
        if (wlog.size() != 132) begin
            errors++; $display("FAIL clr_count: got %0d expected 132", wlog.size());
        end else begin
            for (int i = 0; i < 128; i++) begin
                idx = 7'(i);
                exp = {1'b1, idx, 8'h20};
                checks++;
                if (wlog[i] !== exp) begin
                    errors++; $display("FAIL clr_sweep[%0d]: got %h expected %h", i, wlog[i], exp);
                end
            end
            for (int j = 0; j < 4; j++) begin
                exp = {1'b0, 2'd0, 5'(j), 8'h43};
                checks++;
                if (wlog[128 + j] !== exp) begin
                    errors++; $display("FAIL clr_queued[%0d]: got %h expected %h", j, wlog[128 + j], exp);
                end
            end
        end
        checks++;
        if ({overflow, cur_row, cur_col} !== {1'b1, 2'd0, 5'd4}) begin
            errors++; $display("FAIL clr_overflow_cursor: got %h expected %h",
                               {overflow, cur_row, cur_col}, {1'b1, 2'd0, 5'd4});
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [24:0] outs;
        do_reset();
        send(8'h0C);
        idle(20);
        checks++;
        if ({busy, wr_en} !== 2'b11) begin
            errors++; $display("FAIL midclr_active: busy/wr_en got %b expected 11", {busy, wr_en});
        end
        #2;
        reset_n = 1'b0;
        #1;
        outs = {wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy, overflow};
        checks++;
        if (outs !== 25'd0) begin
            errors++; $display("FAIL midclr_async: outputs got %h expected 0", outs);
        end
        idle(2);
        reset_n = 1'b1;
        wlog.delete();
        send(8'h44);
        idle(5);
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {1'b0, 2'd0, 5'd0, 8'h44}) begin
            errors++; $display("FAIL midclr_after: writes %0d first %h expected 1 %h",
                               wlog.size(), (wlog.size() > 0) ? wlog[0] : 16'h0, {1'b0, 2'd0, 5'd0, 8'h44});
        end
        checks++;
        if ({busy, overflow, cur_row, cur_col} !== {1'b0, 1'b0, 2'd0, 5'd1}) begin
            errors++; $display("FAIL midclr_state: got %h expected %h",
                               {busy, overflow, cur_row, cur_col}, {1'b0, 1'b0, 2'd0, 5'd1});
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_latency();
        test_row_wrap();
        test_cr_lf();
        test_backspace();
        test_clear_overflow();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
